// File: rtl/seven_segment_decoder_if.sv
`default_nettype none
// ============================================================================
//  Module   : seven_segment_decoder_if
//  Brief    : Control/display bundle for the status-display digit decoder:
//             load strobe, code, blank and lamp-test in; seven segment
//             drives plus the out-of-range error flag out.
//  Revision : 1.0 - initial release
// ============================================================================
interface seven_segment_decoder_if;

    // Controller side: what to display and how
    logic       en;
    logic [2:0] inp;
    logic       blank;
    logic       lamp_test;

    // Display side: active-high segment drives and error flag
    logic       seg_a;
    logic       seg_b;
    logic       seg_c;
    logic       seg_d;
    logic       seg_e;
    logic       seg_f;
    logic       seg_g;
    logic       err;

    // Driver of the display controls (controller / testbench)
    modport master (
        output en,
        output inp,
        output blank,
        output lamp_test,
        input  seg_a,
        input  seg_b,
        input  seg_c,
        input  seg_d,
        input  seg_e,
        input  seg_f,
        input  seg_g,
        input  err
    );

    // The decoder itself
    modport slave (
        input  en,
        input  inp,
        input  blank,
        input  lamp_test,
        output seg_a,
        output seg_b,
        output seg_c,
        output seg_d,
        output seg_e,
        output seg_f,
        output seg_g,
        output err
    );

endinterface : seven_segment_decoder_if
`default_nettype wire

// File: rtl/seven_segment_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : seven_segment_decoder
//  Brief    : Registered 3-bit code to common-cathode seven-segment decoder.
//             Codes 0-3 show digits "0".."3"; codes 4-7 show "E" and raise
//             err. Load enable, blanking and lamp test are all resolved in a
//             single synchronous output stage (one clock of latency).
//  Revision : 1.0 - initial release
// ============================================================================
module seven_segment_decoder (
    input  wire                          clk,
    input  wire                          reset,
    seven_segment_decoder_if.slave       bus
);

    // Segment patterns ordered {a,b,c,d,e,f,g}, 1 = lit
    localparam logic [6:0] c_SEG_0   = 7'b1111110;
    localparam logic [6:0] c_SEG_1   = 7'b0110000;
    localparam logic [6:0] c_SEG_2   = 7'b1101101;
    localparam logic [6:0] c_SEG_3   = 7'b1111001;
    localparam logic [6:0] c_SEG_E   = 7'b1001111;
    localparam logic [6:0] c_SEG_ALL = 7'b1111111;
    localparam logic [6:0] c_SEG_OFF = 7'b0000000;

    logic [2:0] code_q;     // code currently held for display
    logic [2:0] sel;        // code that will be held after this edge
    logic [6:0] seg_dec;    // decoded pattern for sel
    logic [6:0] seg_next;   // pattern after blank / lamp-test resolution
    logic [6:0] seg_q;      // registered segment drives
    logic       err_q;      // registered out-of-range flag

    // Choose between a freshly loaded code and the held one
    always_comb begin
        sel = bus.en ? bus.inp : code_q;
    end

    // Map the selected code onto segments; anything above 3 renders "E"
    always_comb begin
        seg_dec = c_SEG_E;
        case (sel)
            3'd0:    seg_dec = c_SEG_0;
            3'd1:    seg_dec = c_SEG_1;
            3'd2:    seg_dec = c_SEG_2;
            3'd3:    seg_dec = c_SEG_3;
            default: seg_dec = c_SEG_E;
        endcase
    end

    // Lamp test beats blanking, blanking beats the decoded digit
    always_comb begin
        if (bus.lamp_test) begin
            seg_next = c_SEG_ALL;
        end else if (bus.blank) begin
            seg_next = c_SEG_OFF;
        end else begin
            seg_next = seg_dec;
        end
    end

    // Single output stage: reset clears everything; err follows the code only
    always_ff @(posedge clk) begin
        if (reset) begin
            code_q <= 3'd0;
            seg_q  <= c_SEG_OFF;
            err_q  <= 1'b0;
        end else begin
            code_q <= sel;
            seg_q  <= seg_next;
            err_q  <= sel[2];   // codes 4..7 all have the MSB set
        end
    end

    assign {bus.seg_a, bus.seg_b, bus.seg_c, bus.seg_d,
            bus.seg_e, bus.seg_f, bus.seg_g} = seg_q;
    assign bus.err = err_q;

endmodule : seven_segment_decoder
`default_nettype wire

// File: tb/tb_seven_segment_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seven_segment_decoder
//  Brief    : Directed self-checking bench for seven_segment_decoder.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_seven_segment_decoder;

    localparam logic [6:0] c_EXP_0   = 7'b1111110;
    localparam logic [6:0] c_EXP_1   = 7'b0110000;
    localparam logic [6:0] c_EXP_2   = 7'b1101101;
    localparam logic [6:0] c_EXP_3   = 7'b1111001;
    localparam logic [6:0] c_EXP_E   = 7'b1001111;
    localparam logic [6:0] c_EXP_ALL = 7'b1111111;
    localparam logic [6:0] c_EXP_OFF = 7'b0000000;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_fail;

    seven_segment_decoder_if bus ();

    seven_segment_decoder dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Safety net so the run can never hang
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [6:0] segs();
        return {bus.seg_a, bus.seg_b, bus.seg_c, bus.seg_d,
                bus.seg_e, bus.seg_f, bus.seg_g};
    endfunction

    // Advance one rising edge and settle 1 ns past it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; bus.en = 1'b0; bus.inp = 3'd0;
        bus.blank = 1'b0; bus.lamp_test = 1'b0;
        step();
        step();
        n_cmp++;
        if (segs() !== c_EXP_OFF) begin
            n_fail++; $display("FAIL reset_seg: got %b want %b", segs(), c_EXP_OFF);
        end
        n_cmp++;
        if (bus.err !== 1'b0) begin
            n_fail++; $display("FAIL reset_err: got %b want 0", bus.err);
        end
        reset = 1'b0;
        step();
        n_cmp++;
        if (segs() !== c_EXP_0) begin
            n_fail++; $display("FAIL post_reset_seg: got %b want %b", segs(), c_EXP_0);
        end
        n_cmp++;
        if (bus.err !== 1'b0) begin
            n_fail++; $display("FAIL post_reset_err: got %b want 0", bus.err);
        end
    endtask

    task automatic test_digits();
        logic [6:0] exp_tbl [4];
        exp_tbl[0] = c_EXP_0; exp_tbl[1] = c_EXP_1;
        exp_tbl[2] = c_EXP_2; exp_tbl[3] = c_EXP_3;
        for (int i = 0; i < 4; i++) begin
            bus.en = 1'b1; bus.inp = 3'(i);
            step();
            n_cmp++;
            if (segs() !== exp_tbl[i]) begin
                n_fail++; $display("FAIL digit_%0d_seg: got %b want %b", i, segs(), exp_tbl[i]);
            end
            n_cmp++;
            if (bus.err !== 1'b0) begin
                n_fail++; $display("FAIL digit_%0d_err: got %b want 0", i, bus.err);
            end
        end
    endtask

    task automatic test_errors();
        for (int i = 4; i < 8; i++) begin
            bus.en = 1'b1; bus.inp = 3'(i);
            step();
            n_cmp++;
            if (segs() !== c_EXP_E) begin
                n_fail++; $display("FAIL code_%0d_seg: got %b want %b", i, segs(), c_EXP_E);
            end
            n_cmp++;
            if (bus.err !== 1'b1) begin
                n_fail++; $display("FAIL code_%0d_err: got %b want 1", i, bus.err);
            end
        end
    endtask

    task automatic test_hold();
        bus.en = 1'b1; bus.inp = 3'd2;
        step();
        bus.en = 1'b0; bus.inp = 3'd7;
        for (int k = 0; k < 2; k++) begin
            step();
            n_cmp++;
            if (segs() !== c_EXP_2) begin
                n_fail++; $display("FAIL hold_%0d_seg: got %b want %b", k, segs(), c_EXP_2);
            end
            n_cmp++;
            if (bus.err !== 1'b0) begin
                n_fail++; $display("FAIL hold_%0d_err: got %b want 0", k, bus.err);
            end
        end
    endtask

    task automatic test_blank_lamp();
        bus.en = 1'b1; bus.inp = 3'd3;
        step();
        bus.en = 1'b0; bus.inp = 3'd0; bus.blank = 1'b1;
        step();
        n_cmp++;
        if (segs() !== c_EXP_OFF) begin
            n_fail++; $display("FAIL blank_seg: got %b want %b", segs(), c_EXP_OFF);
        end
        bus.lamp_test = 1'b1;
        step();
        n_cmp++;
        if (segs() !== c_EXP_ALL) begin
            n_fail++; $display("FAIL lamp_seg: got %b want %b", segs(), c_EXP_ALL);
        end
        n_cmp++;
        if (bus.err !== 1'b0) begin
            n_fail++; $display("FAIL lamp_err: got %b want 0", bus.err);
        end
        bus.blank = 1'b0; bus.lamp_test = 1'b0;
        step();
        n_cmp++;
        if (segs() !== c_EXP_3) begin
            n_fail++; $display("FAIL release_seg: got %b want %b", segs(), c_EXP_3);
        end
    endtask

    // Load and blank in the same cycle, then keep blanking with the code held
    task automatic test_err_blank();
        bus.en = 1'b1; bus.inp = 3'd5; bus.blank = 1'b1;
        step();
        n_cmp++;
        if (segs() !== c_EXP_OFF) begin
            n_fail++; $display("FAIL en_blank_seg: got %b want %b", segs(), c_EXP_OFF);
        end
        n_cmp++;
        if (bus.err !== 1'b1) begin
            n_fail++; $display("FAIL en_blank_err: got %b want 1", bus.err);
        end
        bus.en = 1'b0; bus.inp = 3'd1;
        step();
        n_cmp++;
        if (bus.err !== 1'b1) begin
            n_fail++; $display("FAIL blank_hold_err: got %b want 1", bus.err);
        end
        bus.blank = 1'b0; bus.lamp_test = 1'b1;
        step();
        n_cmp++;
        if (bus.err !== 1'b1) begin
            n_fail++; $display("FAIL lamp_hold_err: got %b want 1", bus.err);
        end
        bus.lamp_test = 1'b0;
        step();
        n_cmp++;
        if (segs() !== c_EXP_E) begin
            n_fail++; $display("FAIL unblank_e_seg: got %b want %b", segs(), c_EXP_E);
        end
    endtask

    // Reset mid-operation overrides load, blank and lamp test
    task automatic test_reset_mid();
        bus.en = 1'b1; bus.inp = 3'd6;
        step();
        reset = 1'b1; bus.en = 1'b1; bus.inp = 3'd1; bus.lamp_test = 1'b1;
        step();
        n_cmp++;
        if (segs() !== c_EXP_OFF) begin
            n_fail++; $display("FAIL mid_reset_seg: got %b want %b", segs(), c_EXP_OFF);
        end
        n_cmp++;
        if (bus.err !== 1'b0) begin
            n_fail++; $display("FAIL mid_reset_err: got %b want 0", bus.err);
        end
        reset = 1'b0; bus.en = 1'b0; bus.lamp_test = 1'b0;
        step();
        n_cmp++;
        if (segs() !== c_EXP_0) begin
            n_fail++; $display("FAIL after_reset_seg: got %b want %b", segs(), c_EXP_0);
        end
        n_cmp++;
        if (bus.err !== 1'b0) begin
            n_fail++; $display("FAIL after_reset_err: got %b want 0", bus.err);
        end
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        reset  = 1'b1;
        bus.en = 1'b0; bus.inp = 3'd0;
        bus.blank = 1'b0; bus.lamp_test = 1'b0;
        test_reset();
        test_digits();
        test_errors();
        test_hold();
        test_blank_lamp();
        test_err_blank();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_seven_segment_decoder
`default_nettype wire
